monster_wave_ctrl: RTL and testbench

- Wave scheduler for the monster slots during play (game_state == PLAY_STATE).
- Drives each slot's 21-bit info word {enable, Y[9:0], X[9:0]} and a one-frame respawn pulse.
- Watches each slot's monster_exist to detect kills, then advances through NUM_WAVES waves and reports level clear.
- Sits between the top-level game FSM and the monster instances; it is the only source of info_monster.

---
 rtl/monster_wave_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_monster_wave_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/monster_wave_ctrl.sv
// Wave scheduler for the monster slots: spawns slots with a frame gap, detects kills,
// steps through NUM_WAVES waves and reports level clear. Optional macro: MONSTER_WAVE_ENDLESS_EN.
module monster_wave_ctrl #(
  parameter int NUM_SLOTS       = 3,
  parameter int NUM_WAVES       = 4,
  parameter int PLAY_STATE      = 2,
  parameter int SPAWN_GAP       = 30,
  parameter int WAVE_GAP_FRAMES = 90,
  parameter int SPAWN_X         = 560,
  parameter int SLOT_DX         = 40,
  parameter int BASE_Y          = 120,
  parameter int SLOT_DY         = 120,
  parameter int WAVE_DY         = 16
) (
  input  logic                     frame_clk,
  input  logic                     Reset,
  input  logic [3:0]               game_state,
  input  logic [NUM_SLOTS-1:0]     monster_exist,
  output logic [21*NUM_SLOTS-1:0]  info_monster,
  output logic [NUM_SLOTS-1:0]     monster_respawn,
  output logic [2:0]               wave_num,
  output logic                     wave_done,
  output logic                     all_clear
);

  localparam logic [3:0]  PLAY       = 4'(PLAY_STATE);
  localparam logic [15:0] SPAWN_LAST = 16'(SPAWN_GAP - 1);
  localparam logic [15:0] GAP_LAST   = 16'(WAVE_GAP_FRAMES - 1);
  localparam logic [2:0]  LAST_WAVE  = 3'(NUM_WAVES - 1);
  localparam logic [2:0]  SLOTS      = 3'(NUM_SLOTS);

  typedef enum logic [2:0] {
    IDLE,
    SPAWN,
    ACTIVE,
    WAVE_GAP,
    CLEAR
  } state_t;

  state_t                 state_reg, state_next;
  logic [2:0]             wave_reg, wave_next;
  logic [2:0]             idx_reg, idx_next;
  logic [15:0]            cnt_reg, cnt_next;
  logic [NUM_SLOTS-1:0]   enable_reg, enable_next;
  logic [NUM_SLOTS-1:0]   killed_reg, killed_next;
  logic [NUM_SLOTS-1:0]   respawn_reg, respawn_next;
  logic [19:0]            pos_reg [NUM_SLOTS];
  logic [19:0]            pos_next [NUM_SLOTS];
  logic [1:0]             mask_reg [NUM_SLOTS];
  logic [1:0]             mask_next [NUM_SLOTS];
  logic                   done_reg, done_next;
  logic                   clear_reg, clear_next;

  logic [2:0]             active_n;
  logic [9:0]             slot_x [NUM_SLOTS];
  logic [9:0]             slot_y [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]   in_wave;
  logic [NUM_SLOTS-1:0]   kill_hit;
  logic                   all_killed;
  logic                   abort;

  always_comb begin
    active_n = (wave_reg >= SLOTS - 3'd1) ? SLOTS : wave_reg + 3'd1;
  end

  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      logic [9:0] y_raw;
      assign slot_x[gi]  = 10'(SPAWN_X - SLOT_DX * gi);
      assign y_raw       = 10'(BASE_Y + SLOT_DY * gi + WAVE_DY * int'(wave_reg));
      // Fold positions that would fall off the bottom of the play field back up.
      assign slot_y[gi]  = (y_raw >= 10'd440) ? y_raw - 10'd400 : y_raw;
      assign in_wave[gi] = 3'(gi) < active_n;
      // A slot cannot be killed while masked: exist lags the respawn pulse.
      assign kill_hit[gi] = enable_reg[gi] & ~monster_exist[gi] & (mask_reg[gi] == 2'd0);
      assign info_monster[21*gi +: 21] = enable_reg[gi] ? {1'b1, pos_reg[gi]} : 21'd0;
    end
  endgenerate

  assign all_killed = &(killed_reg | ~in_wave);
  assign abort      = (state_reg != IDLE) && (game_state != PLAY);

  always_comb begin
    state_next   = state_reg;
    wave_next    = wave_reg;
    idx_next     = idx_reg;
    cnt_next     = cnt_reg;
    enable_next  = enable_reg;
    killed_next  = killed_reg;
    respawn_next = '0;
    done_next    = 1'b0;
    clear_next   = clear_reg;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      pos_next[i]  = pos_reg[i];
      mask_next[i] = (mask_reg[i] != 2'd0) ? mask_reg[i] - 2'd1 : 2'd0;
    end

    case (state_reg)
      IDLE: begin
        if (game_state == PLAY) begin
          state_next = SPAWN;
          wave_next  = 3'd0;
          idx_next   = 3'd0;
          cnt_next   = 16'd0;
        end
      end

      SPAWN: begin
        killed_next = killed_reg | kill_hit;
        if (idx_reg == active_n) begin
          state_next = ACTIVE;
        end else begin
          cnt_next = (cnt_reg == SPAWN_LAST) ? 16'd0 : cnt_reg + 16'd1;
          if (cnt_reg == 16'd0) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
              if (idx_reg == 3'(i)) begin
                enable_next[i]  = 1'b1;
                respawn_next[i] = 1'b1;
                pos_next[i]     = {slot_y[i], slot_x[i]};
                mask_next[i]    = 2'd2;
              end
            end
            idx_next = idx_reg + 3'd1;
          end
        end
      end

      ACTIVE: begin
        if (all_killed) begin
          done_next   = 1'b1;
          enable_next = '0;
          killed_next = '0;
          cnt_next    = 16'd0;
          state_next  = WAVE_GAP;
          for (int i = 0; i < NUM_SLOTS; i++) begin
            pos_next[i] = 20'd0;
          end
        end else begin
          killed_next = killed_reg | kill_hit;
        end
      end

      WAVE_GAP: begin
        if (cnt_reg == GAP_LAST) begin
          idx_next = 3'd0;
          cnt_next = 16'd0;
          if (wave_reg == LAST_WAVE) begin
`ifdef MONSTER_WAVE_ENDLESS_EN
            wave_next  = 3'd0;
            state_next = SPAWN;
`else
            clear_next = 1'b1;
            state_next = CLEAR;
`endif
          end else begin
            wave_next  = wave_reg + 3'd1;
            state_next = SPAWN;
          end
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end

      CLEAR: begin
        enable_next = '0;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Leaving play wins over everything, including a wave completing this frame.
    if (abort) begin
      state_next   = IDLE;
      wave_next    = 3'd0;
      idx_next     = 3'd0;
      cnt_next     = 16'd0;
      enable_next  = '0;
      killed_next  = '0;
      respawn_next = '0;
      done_next    = 1'b0;
      clear_next   = 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        pos_next[i]  = 20'd0;
        mask_next[i] = 2'd0;
      end
    end
  end

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      state_reg   <= IDLE;
      wave_reg    <= 3'd0;
      idx_reg     <= 3'd0;
      cnt_reg     <= 16'd0;
      enable_reg  <= '0;
      killed_reg  <= '0;
      respawn_reg <= '0;
      done_reg    <= 1'b0;
      clear_reg   <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        pos_reg[i]  <= 20'd0;
        mask_reg[i] <= 2'd0;
      end
    end else begin
      state_reg   <= state_next;
      wave_reg    <= wave_next;
      idx_reg     <= idx_next;
      cnt_reg     <= cnt_next;
      enable_reg  <= enable_next;
      killed_reg  <= killed_next;
      respawn_reg <= respawn_next;
      done_reg    <= done_next;
      clear_reg   <= clear_next;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        pos_reg[i]  <= pos_next[i];
        mask_reg[i] <= mask_next[i];
      end
    end
  end

  assign monster_respawn = respawn_reg;
  assign wave_num        = wave_reg;
  assign wave_done       = done_reg;
  assign all_clear       = clear_reg;

endmodule

// File: tb/tb_monster_wave_ctrl.sv
// Self-checking bench for monster_wave_ctrl: directed wave scenarios plus randomized kills
// compared every frame against a timestamp-based model of the wave schedule.
module tb_monster_wave_ctrl;

  localparam int NS = 3;
  localparam int NW = 4;
  localparam int SG = 30;
  localparam int WG = 90;
  localparam logic [3:0] PLAY = 4'd2;
  localparam int VW = 21*NS + NS + 5;

  logic              frame_clk = 1'b0;
  logic              Reset;
  logic [3:0]        game_state;
  logic [NS-1:0]     monster_exist;
  logic [21*NS-1:0]  info_monster;
  logic [NS-1:0]     monster_respawn;
  logic [2:0]        wave_num;
  logic              wave_done;
  logic              all_clear;
  logic [VW-1:0]     obs;

  monster_wave_ctrl dut (
    .frame_clk      (frame_clk),
    .Reset          (Reset),
    .game_state     (game_state),
    .monster_exist  (monster_exist),
    .info_monster   (info_monster),
    .monster_respawn(monster_respawn),
    .wave_num       (wave_num),
    .wave_done      (wave_done),
    .all_clear      (all_clear)
  );

  always #5 frame_clk = ~frame_clk;

  assign obs = {info_monster, monster_respawn, wave_num, wave_done, all_clear};

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: phase 0 idle, 1 spawn, 2 active, 3 gap, 4 clear; events are edge timestamps.
  int          m_phase;
  int          m_t0;
  int          m_wave;
  int          en_edge [NS];
  bit          killed  [NS];
  logic [NS-1:0] m_resp;
  bit          m_done;
  bit          m_clear;

  function automatic void model_reset();
    m_phase = 0; m_t0 = 0; m_wave = 0;
    m_resp = '0; m_done = 0; m_clear = 0;
    for (int j = 0; j < NS; j++) begin
      en_edge[j] = -1;
      killed[j]  = 0;
    end
  endfunction

  function automatic void apply_kills(int n);
    for (int j = 0; j < NS; j++)
      if (en_edge[j] >= 0 && !monster_exist[j] && n >= en_edge[j] + 3) killed[j] = 1;
  endfunction

  function automatic void model_step(int n);
    int an;
    bit all;
    an = (m_wave + 1 < NS) ? m_wave + 1 : NS;
    m_resp = '0;
    m_done = 0;
    if (m_phase != 0 && game_state != PLAY) begin
      model_reset();
      return;
    end
    case (m_phase)
      0: if (game_state == PLAY) begin m_phase = 1; m_t0 = n; m_wave = 0; end
      1: begin
        apply_kills(n);
        for (int j = 0; j < an; j++)
          if (n == m_t0 + 1 + SG*j) begin en_edge[j] = n; m_resp[j] = 1'b1; end
        if (n == m_t0 + 2 + SG*(an-1)) m_phase = 2;
      end
      2: begin
        all = 1;
        for (int j = 0; j < an; j++) all = all & killed[j];
        if (all) begin
          m_done = 1; m_phase = 3; m_t0 = n;
          for (int j = 0; j < NS; j++) begin en_edge[j] = -1; killed[j] = 0; end
        end else begin
          apply_kills(n);
        end
      end
      3: if (n == m_t0 + WG) begin
        if (m_wave == NW - 1) begin
`ifdef MONSTER_WAVE_ENDLESS_EN
          m_wave = 0; m_phase = 1; m_t0 = n;
`else
          m_phase = 4; m_clear = 1;
`endif
        end else begin
          m_wave = m_wave + 1; m_phase = 1; m_t0 = n;
        end
      end
      default: ;
    endcase
  endfunction

  function automatic logic [20:0] slot_word(int j);
    int x, y;
    if (en_edge[j] < 0) return 21'd0;
    x = 560 - 40*j;
    y = (120 + 120*j + 16*m_wave) % 1024;
    if (y >= 440) y = y - 400;
    return {1'b1, 10'(y), 10'(x)};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [21*NS-1:0] info;
    info = '0;
    for (int j = 0; j < NS; j++) info[21*j +: 21] = slot_word(j);
    return {info, m_resp, 3'(m_wave), m_done, m_clear};
  endfunction

  task automatic tick();
    @(posedge frame_clk);
    #1;
    cyc++;
    if (!Reset) model_reset();
    else model_step(cyc);
  endtask

  task automatic test_reset();
    Reset = 1'b0; game_state = 4'd0; monster_exist = '1;
    model_reset();
    repeat (3) tick();
    n_checks++;
    if (obs !== '0) begin n_fail++; $display("FAIL reset_state got=%h exp=0", obs); end
  endtask

  task automatic test_first_spawn();
    logic [20:0] w0;
    w0 = {1'b1, 10'd120, 10'd560};
    game_state = PLAY;
    @(negedge frame_clk); Reset = 1'b1;
    tick();
    n_checks++;
    if (obs !== exp_vec()) begin n_fail++; $display("FAIL model_first cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
    tick();
    n_checks++;
    if (info_monster[20:0] !== w0 || monster_respawn !== 3'b001) begin
      n_fail++; $display("FAIL slot0_enable info=%h resp=%b exp info=%h resp=001", info_monster[20:0], monster_respawn, w0);
    end
    tick();
    n_checks++;
    if (obs !== exp_vec() || monster_respawn !== 3'b000) begin n_fail++; $display("FAIL respawn_one_frame got=%h exp=%h", obs, exp_vec()); end
  endtask

  task automatic test_wave0_kill();
    logic [20:0] w1;
    w1 = {1'b1, 10'd136, 10'd560};
    tick();
    monster_exist[0] = 1'b0;
    tick();
    n_checks++;
    if (obs !== exp_vec() || wave_done !== 1'b0) begin n_fail++; $display("FAIL kill_edge got=%h exp=%h", obs, exp_vec()); end
    tick();
    n_checks++;
    if (wave_done !== 1'b1 || info_monster !== '0) begin
      n_fail++; $display("FAIL wave0_done done=%b info=%h exp done=1 info=0", wave_done, info_monster);
    end
    monster_exist = '1;
    for (int k = 0; k < WG + 1; k++) begin
      tick();
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL model_gap0 cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
    end
    n_checks++;
    if (wave_num !== 3'd1 || info_monster[20:0] !== w1) begin
      n_fail++; $display("FAIL wave1_slot0 wave=%0d info=%h exp wave=1 info=%h", wave_num, info_monster[20:0], w1);
    end
  endtask

  task automatic test_wave1_mask();
    logic [20:0] w;
    bit seen;
    w = {1'b1, 10'd256, 10'd520};
    for (int k = 1; k <= SG; k++) begin
      if (k == 5) monster_exist[0] = 1'b0;
      tick();
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL model_spawn1 cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
    end
    n_checks++;
    if (info_monster[41:21] !== w || monster_respawn !== 3'b010) begin
      n_fail++; $display("FAIL slot1_enable info=%h resp=%b exp info=%h resp=010", info_monster[41:21], monster_respawn, w);
    end
    monster_exist[1] = 1'b0;
    tick();
    monster_exist[1] = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (wave_done) seen = 1;
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL model_mask cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
    end
    n_checks++;
    if (seen) begin n_fail++; $display("FAIL kill_mask wave_done seen=1 exp=0"); end
    monster_exist[1] = 1'b0;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      if (wave_done) seen = 1;
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL model_kill1 cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL wave1_done seen=0 exp=1"); end
    monster_exist = '1;
  endtask

  task automatic test_random_waves();
    bit finished, saw_last;
    int extra;
    finished = 0; saw_last = 0; extra = 0;
    for (int k = 0; k < 4000 && !finished; k++) begin
      for (int j = 0; j < NS; j++) monster_exist[j] = ($urandom_range(0, 9) != 0);
      tick();
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL model_random cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
      if (m_wave == NW - 1) saw_last = 1;
`ifdef MONSTER_WAVE_ENDLESS_EN
      if (saw_last && m_wave == 0 && en_edge[0] >= 0) finished = 1;
`else
      if (m_clear) begin extra++; if (extra > 5) finished = 1; end
`endif
    end
    n_checks++;
`ifdef MONSTER_WAVE_ENDLESS_EN
    if (!finished || wave_num !== 3'd0 || all_clear !== 1'b0) begin
      n_fail++; $display("FAIL endless_wrap done=%0d wave=%0d clear=%b exp wave=0 clear=0", finished, wave_num, all_clear);
    end
`else
    if (!finished || all_clear !== 1'b1 || info_monster !== '0) begin
      n_fail++; $display("FAIL all_clear done=%0d clear=%b info=%h exp clear=1 info=0", finished, all_clear, info_monster);
    end
`endif
  endtask

  task automatic test_abort();
    game_state = 4'd0;
    monster_exist = '1;
    tick();
    n_checks++;
    if (obs !== '0) begin n_fail++; $display("FAIL abort_outputs got=%h exp=0", obs); end
    game_state = PLAY;
    tick();
    n_checks++;
    if (obs !== '0) begin n_fail++; $display("FAIL idle_restart got=%h exp=0", obs); end
    tick();
    n_checks++;
    if (obs !== exp_vec() || monster_respawn !== 3'b001 || wave_num !== 3'd0) begin
      n_fail++; $display("FAIL restart_spawn got=%h exp=%h", obs, exp_vec());
    end
  endtask

  task automatic test_async_reset();
    bit hit;
    hit = 0;
    for (int k = 0; k < 3000 && !hit; k++) begin
      for (int j = 0; j < NS; j++) monster_exist[j] = ($urandom_range(0, 9) != 0);
      tick();
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL model_async cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
      if (m_phase == 1 && m_wave == 2 && en_edge[1] >= 0 && en_edge[2] < 0) hit = 1;
    end
    n_checks++;
    if (!hit || info_monster[41:21] === 21'd0) begin
      n_fail++; $display("FAIL reach_w2s1 reached=%0d slot1=%h exp enabled", hit, info_monster[41:21]);
    end
    #2 Reset = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (obs !== '0) begin n_fail++; $display("FAIL async_reset got=%h exp=0", obs); end
    monster_exist = '1;
    tick();
    n_checks++;
    if (obs !== '0) begin n_fail++; $display("FAIL reset_hold got=%h exp=0", obs); end
    @(negedge frame_clk); Reset = 1'b1;
  endtask

  task automatic test_abort_last_kill();
    bit up;
    up = 0;
    for (int k = 0; k < 5 && !up; k++) begin
      tick();
      if (en_edge[0] >= 0) up = 1;
    end
    n_checks++;
    if (!up || info_monster[20:0] !== {1'b1, 10'd120, 10'd560}) begin
      n_fail++; $display("FAIL post_reset_spawn slot0=%h exp=%h", info_monster[20:0], {1'b1, 10'd120, 10'd560});
    end
    tick(); tick();
    monster_exist[0] = 1'b0;
    tick();
    game_state = 4'd0;
    tick();
    n_checks++;
    if (wave_done !== 1'b0 || obs !== exp_vec() || obs !== '0) begin
      n_fail++; $display("FAIL abort_vs_kill done=%b got=%h exp=0", wave_done, obs);
    end
  endtask

  initial begin
    test_reset();
    test_first_spawn();
    test_wave0_kill();
    test_wave1_mask();
    test_random_waves();
    test_abort();
    test_async_reset();
    test_abort_last_kill();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
